// File: rtl/lif_neuron.sv
// lif_neuron -- single digital leaky integrate-and-fire neuron.
//
// Each enabled cycle the membrane potential leaks by v >> LEAK_SHIFT, the
// unsigned input current is added, and the result saturates at 255. When the
// updated potential reaches THRESHOLD the neuron emits a one-cycle spike,
// reloads V_RESET and ignores input for REFRACTORY enabled cycles.
//
// Ports:
//   clk      in   1  clock, all state updates on the rising edge
//   reset_n  in   1  synchronous reset, active HIGH despite the name
//   current  in   8  unsigned input current, sampled every enabled cycle
//   stop     in   1  1 = freeze (hold potential and refractory count)
//   v_out    out  8  membrane potential register
//   spike    out  1  one-cycle firing pulse, coincides with v_out = V_RESET
//
// All outputs are registers; there is no combinational input-to-output path.

module lif_neuron #(
  parameter logic [7:0]  THRESHOLD  = 8'd200,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter logic [7:0]  V_RESET    = 8'd0,
  parameter int unsigned REFRACTORY = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] current,
  input  logic       stop,
  output logic [7:0] v_out,
  output logic       spike
);

  // Counter must hold REFRACTORY; keep at least one bit when REFRACTORY = 0.
  localparam int unsigned CW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  logic [7:0]    v_q;
  logic          spike_q;
  logic [CW-1:0] refr_q;

  logic [7:0]    leak;
  logic [9:0]    sum;
  logic [7:0]    v_next;
  logic          fire;

  // Leak never exceeds v, so the subtraction cannot underflow; the 10-bit
  // sum holds at most 255 + 255 and is clamped instead of wrapping.
  always_comb begin
    leak   = v_q >> LEAK_SHIFT;
    sum    = {2'b00, v_q} - {2'b00, leak} + {2'b00, current};
    v_next = (sum > 10'd255) ? 8'hFF : sum[7:0];
    fire   = (v_next >= THRESHOLD);
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      v_q     <= V_RESET;
      spike_q <= 1'b0;
      refr_q  <= '0;
    end else if (stop) begin
      spike_q <= 1'b0;
    end else if (refr_q != '0) begin
      v_q     <= V_RESET;
      spike_q <= 1'b0;
      refr_q  <= refr_q - CW'(1);
    end else if (fire) begin
      v_q     <= V_RESET;
      spike_q <= 1'b1;
      refr_q  <= CW'(REFRACTORY);
    end else begin
      v_q     <= v_next;
      spike_q <= 1'b0;
    end
  end

  assign v_out = v_q;
  assign spike = spike_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed testbench for lif_neuron with default parameters
// (THRESHOLD=200, LEAK_SHIFT=3, V_RESET=0, REFRACTORY=2).

module tb_lif_neuron;

  logic       clk;
  logic       reset_n;
  logic [7:0] current;
  logic       stop;
  logic [7:0] v_out;
  logic       spike;

  int n_checks = 0;
  int n_pass   = 0;

  lif_neuron #(
    .THRESHOLD  (8'd200),
    .LEAK_SHIFT (3),
    .V_RESET    (8'd0),
    .REFRACTORY (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .current (current),
    .stop    (stop),
    .v_out   (v_out),
    .spike   (spike)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    stop    = 1'b0;
    current = 8'd0;
    step();
    reset_n = 1'b0;
  endtask

  initial begin
    int exp_ramp[4] = '{16, 30, 43, 54};
    bit seen_spike;

    reset_n = 1'b1;
    stop    = 1'b0;
    current = 8'd50;
    #1;

    // Reset held two cycles with nonzero current
    step();
    check("rst1_v", v_out, 0);
    check("rst1_spk", spike, 0);
    step();
    check("rst2_v", v_out, 0);
    check("rst2_spk", spike, 0);
    reset_n = 1'b0;
    current = 8'd0;
    step();
    check("idle_v0", v_out, 0);
    step();
    check("idle_v1", v_out, 0);

    // Integration with leak
    current = 8'd16;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("ramp%0d_v", i), v_out, exp_ramp[i]);
      check($sformatf("ramp%0d_spk", i), spike, 0);
    end
    seen_spike = 1'b0;
    for (int i = 0; i < 196; i++) begin
      step();
      if (spike) seen_spike = 1'b1;
    end
    check("settle_nospike", int'(seen_spike), 0);
    check("settle_range", int'(v_out >= 8'd128 && v_out <= 8'd135), 1);

    // Fire with saturation, then refractory
    do_reset();
    current = 8'd100;
    step();
    check("fire_v100", v_out, 100);
    step();
    check("fire_v188", v_out, 188);
    step();
    check("fire_v", v_out, 0);
    check("fire_spk", spike, 1);
    step();
    check("refr1_v", v_out, 0);
    check("refr1_spk", spike, 0);
    step();
    check("refr2_v", v_out, 0);
    check("refr2_spk", spike, 0);
    step();
    check("resume_v", v_out, 100);
    check("resume_spk", spike, 0);

    // Exact threshold fires
    do_reset();
    current = 8'd200;
    step();
    check("thr_spk", spike, 1);
    check("thr_v", v_out, 0);

    // Stop holds state; stop during refractory freezes the counter
    do_reset();
    current = 8'd100;
    step();
    step();
    check("stop_pre_v", v_out, 188);
    stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stop%0d_v", i), v_out, 188);
      check($sformatf("stop%0d_spk", i), spike, 0);
    end
    stop = 1'b0;
    step();
    check("stop_fire_spk", spike, 1);
    check("stop_fire_v", v_out, 0);
    step();
    check("stop_refr_v", v_out, 0);
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stop_refr%0d_v", i), v_out, 0);
      check($sformatf("stop_refr%0d_spk", i), spike, 0);
    end
    stop = 1'b0;
    step();
    check("refr_frozen_v", v_out, 0);
    step();
    check("refr_done_v", v_out, 100);

    // Reset mid-refractory together with stop
    do_reset();
    current = 8'd100;
    step();
    step();
    step();
    check("mid_fire_spk", spike, 1);
    step();
    reset_n = 1'b1;
    stop    = 1'b1;
    step();
    check("mid_rst_v", v_out, 0);
    check("mid_rst_spk", spike, 0);
    reset_n = 1'b0;
    stop    = 1'b0;
    current = 8'd100;
    step();
    check("mid_after_v", v_out, 100);
    check("mid_after_spk", spike, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
